// File: rtl/simpconv_pkg.sv
// Shared definitions for the layer ping-pong scheduler: FSM state encoding and
// default widths used by the scheduler and its bank router.
package simpconv_pkg;

    localparam int DEF_ADDR_WIDTH = 9;
    localparam int DEF_CNT_WIDTH  = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } fsm_state_e;

endpackage

// File: rtl/pingpong_bank_mux.sv
// Zero-latency port router for one feature bank: the producer wins, the consumer
// gets read-only access, and an unowned bank sees idle zeros.
module pingpong_bank_mux
    import simpconv_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  prod_route,
    input  logic                  cons_route,
    input  logic [ADDR_WIDTH-1:0] prod_addr_a,
    input  logic [ADDR_WIDTH-1:0] prod_addr_b,
    input  logic                  prod_rden_a,
    input  logic                  prod_rden_b,
    input  logic                  prod_wren_a,
    input  logic                  prod_wren_b,
    input  logic [ADDR_WIDTH-1:0] cons_addr_a,
    input  logic [ADDR_WIDTH-1:0] cons_addr_b,
    input  logic                  cons_rden_a,
    input  logic                  cons_rden_b,
    output logic [ADDR_WIDTH-1:0] bank_addr_a,
    output logic [ADDR_WIDTH-1:0] bank_addr_b,
    output logic                  bank_rden_a,
    output logic                  bank_rden_b,
    output logic                  bank_wren_a,
    output logic                  bank_wren_b
);

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        bank_addr_a = '0;
        bank_addr_b = '0;
        bank_rden_a = 1'b0;
        bank_rden_b = 1'b0;
        bank_wren_a = 1'b0;
        bank_wren_b = 1'b0;
        if (prod_route) begin
            bank_addr_a = prod_addr_a;
            bank_addr_b = prod_addr_b;
            bank_rden_a = prod_rden_a;
            bank_rden_b = prod_rden_b;
            bank_wren_a = prod_wren_a;
            bank_wren_b = prod_wren_b;
        end else if (cons_route) begin
            bank_addr_a = cons_addr_a;
            bank_addr_b = cons_addr_b;
            bank_rden_a = cons_rden_a;
            bank_rden_b = cons_rden_b;
        end
    end

endmodule

// File: rtl/layer_pingpong_scheduler.sv
// Double-buffered producer/consumer scheduler: two feature banks alternate between
// a producing layer and a consuming layer, tracked by per-bank full flags.
module layer_pingpong_scheduler
    import simpconv_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  prod_done,
    input  logic                  cons_done,
    output logic                  prod_enable,
    output logic                  prod_reset,
    output logic                  cons_enable,
    output logic                  cons_reset,
    input  logic [ADDR_WIDTH-1:0] prod_addr_a,
    input  logic [ADDR_WIDTH-1:0] prod_addr_b,
    input  logic                  prod_rden_a,
    input  logic                  prod_rden_b,
    input  logic                  prod_wren_a,
    input  logic                  prod_wren_b,
    input  logic [ADDR_WIDTH-1:0] cons_addr_a,
    input  logic [ADDR_WIDTH-1:0] cons_addr_b,
    input  logic                  cons_rden_a,
    input  logic                  cons_rden_b,
    output logic [ADDR_WIDTH-1:0] bank0_addr_a,
    output logic [ADDR_WIDTH-1:0] bank0_addr_b,
    output logic                  bank0_rden_a,
    output logic                  bank0_rden_b,
    output logic                  bank0_wren_a,
    output logic                  bank0_wren_b,
    output logic [ADDR_WIDTH-1:0] bank1_addr_a,
    output logic [ADDR_WIDTH-1:0] bank1_addr_b,
    output logic                  bank1_rden_a,
    output logic                  bank1_rden_b,
    output logic                  bank1_wren_a,
    output logic                  bank1_wren_b,
    output logic                  prod_bank_sel,
    output logic                  cons_bank_sel,
    output logic [CNT_WIDTH-1:0]  frame_count,
    output logic                  busy
);

    fsm_state_e           prod_state, prod_state_next;
    fsm_state_e           cons_state, cons_state_next;
    logic [1:0]           full, full_next;
    logic                 prod_bank_sel_next, cons_bank_sel_next;
    logic [CNT_WIDTH-1:0] frame_count_next;
    logic                 prod_fire, cons_fire;
    logic [1:0]           prod_route, cons_route;

    always_ff @(posedge clock) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            prod_state    <= ST_IDLE;
            cons_state    <= ST_IDLE;
            full          <= 2'b00;
            prod_bank_sel <= 1'b0;
            cons_bank_sel <= 1'b0;
            frame_count   <= '0;
        end else begin
            prod_state    <= prod_state_next;
            cons_state    <= cons_state_next;
            full          <= full_next;
            prod_bank_sel <= prod_bank_sel_next;
            cons_bank_sel <= cons_bank_sel_next;
            frame_count   <= frame_count_next;
        end
    end

    // Done pulses only count while the matching side is actually running a frame.
    assign prod_fire = (prod_state == ST_RUN) && prod_done;
    assign cons_fire = (cons_state == ST_RUN) && cons_done;

    always_comb begin
        prod_state_next    = prod_state;
        cons_state_next    = cons_state;
        full_next          = full;
        prod_bank_sel_next = prod_bank_sel;
        cons_bank_sel_next = cons_bank_sel;
        frame_count_next   = frame_count;

        case (prod_state)
            ST_IDLE: if (enable && !full[prod_bank_sel]) prod_state_next = ST_RUN;
            ST_RUN:  if (prod_done) prod_state_next = ST_IDLE;
            default: prod_state_next = ST_IDLE;
        endcase

        case (cons_state)
            ST_IDLE: if (full[cons_bank_sel]) cons_state_next = ST_RUN;
            ST_RUN:  if (cons_done) cons_state_next = ST_IDLE;
            default: cons_state_next = ST_IDLE;
        endcase

        // The two sides always own different banks, so both flag updates can land together.
        if (prod_fire) begin
            full_next[prod_bank_sel] = 1'b1;
            prod_bank_sel_next       = ~prod_bank_sel;
        end
        if (cons_fire) begin
            full_next[cons_bank_sel] = 1'b0;
            cons_bank_sel_next       = ~cons_bank_sel;
            frame_count_next         = frame_count + 1'b1;
        end
    end

    always_comb begin
        prod_enable   = (prod_state == ST_RUN);
        prod_reset    = (prod_state != ST_RUN);
        cons_enable   = (cons_state == ST_RUN);
        cons_reset    = (cons_state != ST_RUN);
        busy          = prod_enable || cons_enable || (|full);
        prod_route[0] = prod_enable && !prod_bank_sel;
        prod_route[1] = prod_enable &&  prod_bank_sel;
        cons_route[0] = cons_enable && !cons_bank_sel;
        cons_route[1] = cons_enable &&  cons_bank_sel;
    end

    pingpong_bank_mux #(.ADDR_WIDTH(ADDR_WIDTH)) u_bank0_mux (
        .prod_route  (prod_route[0]),
        .cons_route  (cons_route[0]),
        .prod_addr_a (prod_addr_a),
        .prod_addr_b (prod_addr_b),
        .prod_rden_a (prod_rden_a),
        .prod_rden_b (prod_rden_b),
        .prod_wren_a (prod_wren_a),
        .prod_wren_b (prod_wren_b),
        .cons_addr_a (cons_addr_a),
        .cons_addr_b (cons_addr_b),
        .cons_rden_a (cons_rden_a),
        .cons_rden_b (cons_rden_b),
        .bank_addr_a (bank0_addr_a),
        .bank_addr_b (bank0_addr_b),
        .bank_rden_a (bank0_rden_a),
        .bank_rden_b (bank0_rden_b),
        .bank_wren_a (bank0_wren_a),
        .bank_wren_b (bank0_wren_b)
    );

    pingpong_bank_mux #(.ADDR_WIDTH(ADDR_WIDTH)) u_bank1_mux (
        .prod_route  (prod_route[1]),
        .cons_route  (cons_route[1]),
        .prod_addr_a (prod_addr_a),
        .prod_addr_b (prod_addr_b),
        .prod_rden_a (prod_rden_a),
        .prod_rden_b (prod_rden_b),
        .prod_wren_a (prod_wren_a),
        .prod_wren_b (prod_wren_b),
        .cons_addr_a (cons_addr_a),
        .cons_addr_b (cons_addr_b),
        .cons_rden_a (cons_rden_a),
        .cons_rden_b (cons_rden_b),
        .bank_addr_a (bank1_addr_a),
        .bank_addr_b (bank1_addr_b),
        .bank_rden_a (bank1_rden_a),
        .bank_rden_b (bank1_rden_b),
        .bank_wren_a (bank1_wren_a),
        .bank_wren_b (bank1_wren_b)
    );

endmodule

// File: tb/tb_layer_pingpong_scheduler.sv
// Self-checking bench: a frame-count model (banks alternate, occupancy = produced - consumed)
// is compared every cycle, with directed scenarios pinned by literal expectations.
module tb_layer_pingpong_scheduler;

    localparam int AW = 9;
    localparam int CW = 8;

    logic          clock = 1'b0;
    logic          reset, enable, prod_done, cons_done;
    logic          prod_enable, prod_reset, cons_enable, cons_reset;
    logic [AW-1:0] prod_addr_a, prod_addr_b, cons_addr_a, cons_addr_b;
    logic          prod_rden_a, prod_rden_b, prod_wren_a, prod_wren_b;
    logic          cons_rden_a, cons_rden_b;
    logic [AW-1:0] bank0_addr_a, bank0_addr_b, bank1_addr_a, bank1_addr_b;
    logic          bank0_rden_a, bank0_rden_b, bank0_wren_a, bank0_wren_b;
    logic          bank1_rden_a, bank1_rden_b, bank1_wren_a, bank1_wren_b;
    logic          prod_bank_sel, cons_bank_sel, busy;
    logic [CW-1:0] frame_count;

    always #5 clock = ~clock;

    layer_pingpong_scheduler #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .clock(clock), .reset(reset), .enable(enable),
        .prod_done(prod_done), .cons_done(cons_done),
        .prod_enable(prod_enable), .prod_reset(prod_reset),
        .cons_enable(cons_enable), .cons_reset(cons_reset),
        .prod_addr_a(prod_addr_a), .prod_addr_b(prod_addr_b),
        .prod_rden_a(prod_rden_a), .prod_rden_b(prod_rden_b),
        .prod_wren_a(prod_wren_a), .prod_wren_b(prod_wren_b),
        .cons_addr_a(cons_addr_a), .cons_addr_b(cons_addr_b),
        .cons_rden_a(cons_rden_a), .cons_rden_b(cons_rden_b),
        .bank0_addr_a(bank0_addr_a), .bank0_addr_b(bank0_addr_b),
        .bank0_rden_a(bank0_rden_a), .bank0_rden_b(bank0_rden_b),
        .bank0_wren_a(bank0_wren_a), .bank0_wren_b(bank0_wren_b),
        .bank1_addr_a(bank1_addr_a), .bank1_addr_b(bank1_addr_b),
        .bank1_rden_a(bank1_rden_a), .bank1_rden_b(bank1_rden_b),
        .bank1_wren_a(bank1_wren_a), .bank1_wren_b(bank1_wren_b),
        .prod_bank_sel(prod_bank_sel), .cons_bank_sel(cons_bank_sel),
        .frame_count(frame_count), .busy(busy)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Model: frames are produced/consumed strictly alternating between banks, so the
    // bank of each side is its frame count mod 2 and occupancy is produced - consumed.
    int m_pf = 0, m_cf = 0;
    bit m_prun = 0, m_crun = 0, model_valid = 0;

    always @(posedge clock) begin
        if (reset) begin
            m_pf = 0; m_cf = 0; m_prun = 0; m_crun = 0; model_valid = 1;
        end else if (model_valid) begin
            int  occ;
            bit  p_fire, c_fire;
            occ    = m_pf - m_cf;
            p_fire = m_prun && prod_done;
            c_fire = m_crun && cons_done;
            m_prun = m_prun ? !prod_done : (enable && occ < 2);
            m_crun = m_crun ? !cons_done : (occ > 0);
            if (p_fire) m_pf++;
            if (c_fire) m_cf++;
        end
    end

    function automatic logic [2*AW+3:0] exp_bank(input int n);
        if (m_prun && (m_pf % 2) == n)
            return {prod_addr_a, prod_addr_b, prod_rden_a, prod_rden_b, prod_wren_a, prod_wren_b};
        else if (m_crun && (m_cf % 2) == n)
            return {cons_addr_a, cons_addr_b, cons_rden_a, cons_rden_b, 2'b00};
        return '0;
    endfunction

    always @(negedge clock) begin
        if (model_valid) begin
            check("prod_enable", prod_enable, m_prun);
            check("prod_reset", prod_reset, !m_prun);
            check("cons_enable", cons_enable, m_crun);
            check("cons_reset", cons_reset, !m_crun);
            check("prod_bank_sel", prod_bank_sel, m_pf % 2);
            check("cons_bank_sel", cons_bank_sel, m_cf % 2);
            check("frame_count", frame_count, m_cf % 256);
            check("busy", busy, m_prun || m_crun || (m_pf != m_cf));
            check("bank0_ports", {bank0_addr_a, bank0_addr_b, bank0_rden_a, bank0_rden_b,
                                  bank0_wren_a, bank0_wren_b}, exp_bank(0));
            check("bank1_ports", {bank1_addr_a, bank1_addr_b, bank1_rden_a, bank1_rden_b,
                                  bank1_wren_a, bank1_wren_b}, exp_bank(1));
        end
    end

    bit rand_en = 1;

    task automatic rand_bus();
        prod_addr_a = AW'($urandom); prod_addr_b = AW'($urandom);
        cons_addr_a = AW'($urandom); cons_addr_b = AW'($urandom);
        {prod_rden_a, prod_rden_b, prod_wren_a, prod_wren_b} = 4'($urandom);
        {cons_rden_a, cons_rden_b} = 2'($urandom);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        if (rand_en) rand_bus();
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_prod_enable"}, prod_enable, 1'b0);
        check({tag, "_prod_reset"}, prod_reset, 1'b1);
        check({tag, "_cons_enable"}, cons_enable, 1'b0);
        check({tag, "_cons_reset"}, cons_reset, 1'b1);
        check({tag, "_sels"}, {prod_bank_sel, cons_bank_sel}, 2'b00);
        check({tag, "_frame_count"}, frame_count, 8'd0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_full"}, dut.full, 2'b00);
        check({tag, "_bank_strobes"}, {bank0_rden_a, bank0_rden_b, bank0_wren_a, bank0_wren_b,
                                       bank1_rden_a, bank1_rden_b, bank1_wren_a, bank1_wren_b}, 8'h00);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1; enable = 0; prod_done = 0; cons_done = 0;
        rand_bus();
        repeat (3) tick();
        check_reset_state("por");

        // Startup timing: enable at cycle 0, producer done at cycle 10.
        reset = 0; enable = 1;
        tick();
        check("c1_prod_enable", prod_enable, 1'b1);
        repeat (9) tick();
        prod_done = 1; tick(); prod_done = 0;
        check("c11_prod_bank_sel", prod_bank_sel, 1'b1);
        tick();
        check("c12_full", dut.full, 2'b01);
        check("c12_prod_enable", prod_enable, 1'b1);
        check("c12_cons_enable", cons_enable, 1'b1);
        check("c12_prod_bank_sel", prod_bank_sel, 1'b1);

        // Simultaneous completion on both sides.
        repeat (3) tick();
        prod_done = 1; cons_done = 1; tick(); prod_done = 0; cons_done = 0;
        check("sim_frame_count", frame_count, 8'd1);
        check("sim_sels", {prod_bank_sel, cons_bank_sel}, 2'b01);
        check("sim_full", dut.full, 2'b10);
        tick();

        // Reset while both sides run.
        reset = 1; tick();
        check_reset_state("midrun");
        reset = 0;

        // Consumer stalled until both banks are full.
        tick();
        prod_done = 1; tick(); prod_done = 0;
        tick();
        prod_done = 1; tick(); prod_done = 0;
        repeat (3) tick();
        check("stall_full", dut.full, 2'b11);
        check("stall_prod_enable", prod_enable, 1'b0);
        check("stall_prod_reset", prod_reset, 1'b1);
        cons_done = 1; tick(); cons_done = 0;
        check("free_t1_prod_enable", prod_enable, 1'b0);
        tick();
        check("free_t2_prod_enable", prod_enable, 1'b1);
        check("free_t2_prod_bank", prod_bank_sel, 1'b0);

        // Enable dropped mid-frame: frame completes, consumer drains.
        enable = 0;
        repeat (2) tick();
        prod_done = 1; tick(); prod_done = 0;
        repeat (3) tick();
        check("drain_prod_idle", prod_enable, 1'b0);
        cons_done = 1; tick(); cons_done = 0;
        repeat (2) tick();
        cons_done = 1; tick(); cons_done = 0;
        repeat (3) tick();
        check("drain_busy", busy, 1'b0);
        check("drain_frame_count", frame_count, 8'd3);

        // Consumer alone on bank 1 with producer write strobes asserted.
        rand_en = 0;
        prod_addr_a = 9'h055; prod_addr_b = 9'h0AA;
        {prod_rden_a, prod_rden_b, prod_wren_a, prod_wren_b} = 4'b1111;
        cons_addr_a = 9'h000; cons_addr_b = 9'h000; cons_rden_a = 0; cons_rden_b = 0;
        enable = 1; tick();
        enable = 0; prod_done = 1; tick(); prod_done = 0;
        tick();
        cons_rden_a = 1; cons_addr_a = 9'h1A5; cons_addr_b = 9'h0F0;
        #1;
        check("rd_bank1_addr_a", bank1_addr_a, 9'h1A5);
        check("rd_bank1_rden_a", bank1_rden_a, 1'b1);
        check("rd_bank1_wren", {bank1_wren_a, bank1_wren_b}, 2'b00);
        check("rd_bank0_idle", {bank0_addr_a, bank0_addr_b, bank0_rden_a, bank0_rden_b,
                                bank0_wren_a, bank0_wren_b}, 22'd0);
        cons_done = 1; tick(); cons_done = 0;
        repeat (2) tick();
        rand_en = 1;

        // Frame counter wrap after 256 consumed frames.
        enable = 1; prod_done = 1; cons_done = 1;
        for (int i = 0; i < 5000 && m_cf < 256; i++) tick();
        prod_done = 0; cons_done = 0;
        if (m_cf != 256) begin
            vectors++; miscompares++;
            $display("FAIL wrap_bound: consumed %0d frames, expected 256", m_cf);
        end
        check("wrap_frame_count", frame_count, 8'd0);

        // Reset asserted while the producer is running.
        for (int i = 0; i < 8 && !m_prun; i++) tick();
        check("pre_reset_prod_run", prod_enable, 1'b1);
        reset = 1; tick();
        check_reset_state("run_reset");
        reset = 0; enable = 0;
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
